// File: rtl/dump_pkg.sv
// Shared types and constants for the memory dump streamer: FSM states and
// stream framing constants.
package dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_CKSUM,
    S_FIN
  } dump_state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam int          BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam logic [7:0]  CKSUM_INIT     = 8'h00;

endpackage

// File: rtl/mem_dump_streamer_if.sv
// Command, memory-port and byte-stream signals of the dump streamer.
// The master modport is the dump engine; the slave modport is its environment.
interface mem_dump_streamer_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 11
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   busy;
  logic                   done;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd_en;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic [7:0]             out_byte;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  start, base_addr, word_count, mem_rdata, out_ready,
    output busy, done, mem_addr, mem_rd_en, out_byte, out_valid
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, out_ready,
    input  busy, done, mem_addr, mem_rd_en, out_byte, out_valid
  );
endinterface

// File: rtl/dump_byte_serializer.sv
// Splits a captured 32-bit word into bytes, MSB first, and accumulates the
// XOR checksum of every byte that has handshaken.
module dump_byte_serializer
  import dump_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic [31:0] word_i,
  output logic [7:0]  out_byte_o,
  output logic [7:0]  cksum_o,
  output logic        last_byte_o
);

  logic [31:0]           shift_q, shift_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]            cksum_q, cksum_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    shift_d = shift_q;
    idx_d   = idx_q;
    cksum_d = cksum_q;
    if (clear_i) begin
      cksum_d = CKSUM_INIT;
    end
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
    end else if (advance_i) begin
      shift_d = {shift_q[23:0], 8'h00};
      idx_d   = idx_q + 1'b1;
      cksum_d = cksum_q ^ shift_q[31:24];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      cksum_q <= CKSUM_INIT;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
    end
  end

  assign out_byte_o  = shift_q[31:24];
  assign cksum_o     = cksum_q;
  assign last_byte_o = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_dump_streamer.sv
// Reads a contiguous word range from a synchronous-read memory and streams it
// as bytes (MSB first) over valid/ready, followed by one XOR checksum byte.
module mem_dump_streamer
  import dump_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 11
) (
  input logic                 clk,
  input logic                 reset,
  mem_dump_streamer_if.master bus
);

  dump_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

  logic                   ser_clear, ser_load, ser_advance, ser_last;
  logic [7:0]             ser_byte, ser_cksum;
  logic [DATA_WIDTH-1:0]  rdata;

  logic                   busy, done, rd_en, out_valid;
  logic [7:0]             out_byte;

  assign rdata = bus.mem_rdata;

  dump_byte_serializer u_serializer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (ser_clear),
    .load_i      (ser_load),
    .advance_i   (ser_advance),
    .word_i      (rdata),
    .out_byte_o  (ser_byte),
    .cksum_o     (ser_cksum),
    .last_byte_o (ser_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    ser_clear   = 1'b0;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rd_en       = 1'b0;
    out_valid   = 1'b0;
    out_byte    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.word_count;
          ser_clear   = 1'b1;
          state_d     = (bus.word_count == '0) ? S_CKSUM : S_REQ;
        end
      end
      S_REQ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        ser_load = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_byte  = ser_byte;
        if (bus.out_ready) begin
          ser_advance = 1'b1;
          if (ser_last) begin
            // Address wraps silently at the top of memory.
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            state_d     = (remaining_q == COUNT_WIDTH'(1)) ? S_CKSUM : S_REQ;
          end
        end
      end
      S_CKSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_byte  = ser_cksum;
        if (bus.out_ready) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_en;
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = out_byte;

endmodule
